hex_keypad_encoder: RTL and testbench
=====================================

Name: hex_keypad_encoder

Overview:
- Scans a 4x4 hex keypad (Pmod KYPD on the Nexys3 JA header) and encodes one debounced key press into a 4-bit hex code.
- It is the input-side counterpart of the seven-segment hex decoder: the user enters nibbles here, and the processor or display path consumes them.
- Output is a one-cycle valid pulse per press plus a held level.

Parameters:
- SCAN_DIV, 100000, clk cycles each column is driven before its rows are sampled (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-keypad scans needed to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- row  input  4  keypad row lines, active-low, externally pulled up; asynchronous to clk.
- col  output  4  keypad column drive, active-low, exactly one bit low at any time.
- keyCode  output  4  hex code of the last accepted key; holds its value until the next accepted press.
- keyValid  output  1  one-cycle pulse when a new press is accepted.
- keyHeld  output  1  high from acceptance until the release is accepted.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - col = 4'b1110
  - keyCode = 0, keyValid = 0, keyHeld = 0
  - dwell counter = 0, column index = 0, debounce counter = 0
  - row synchronizer flops = 4'b1111
  - FSM = IDLE
  - Reset asserted mid-scan or mid-press aborts immediately. No keyValid is emitted on reset or on reset release.
- Synchronizer: row passes through a 2-flop synchronizer. Only the synchronized value is used.
- Column scan:
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the cycle the counter equals SCAN_DIV-1, the synchronized rows for the current column are captured, the counter wraps to 0, and col rotates to the next column (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - A full scan is 4*SCAN_DIV cycles. Scan result is evaluated on the capture of column 3.
- Scan result, computed over the 16 captured bits:
  - NONE: no bit low.
  - SINGLE(code): exactly one bit low.
  - MULTI: two or more bits low.
- Keymap, row 0..3 top to bottom:
  - column 0: 1, 4, 7, 0
  - column 1: 2, 5, 8, F
  - column 2: 3, 6, 9, E
  - column 3: A, B, C, D
- FSM, evaluated once per completed scan. The debounce counter is cnt.
  - IDLE:
    - SINGLE(c): candidate <= c, cnt <= 1, go to CONFIRM. If DEBOUNCE_SCANS = 1, go straight to PRESSED.
    - NONE or MULTI: stay in IDLE.
  - CONFIRM:
    - SINGLE(same c): cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED.
    - SINGLE(different c): restart with the new candidate, cnt <= 1.
    - NONE or MULTI: go to IDLE, cnt <= 0.
  - Entering PRESSED:
    - keyCode <= candidate, keyValid = 1 for exactly one clk, keyHeld <= 1.
  - PRESSED:
    - NONE: cnt <= 1, go to RELEASE.
    - SINGLE or MULTI of any code: stay in PRESSED. No new pulse; rollover is ignored until full release.
  - RELEASE:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, keyHeld <= 0 and go to IDLE.
    - Any key: go back to PRESSED, no pulse.
- Latency: keyValid is asserted on the cycle after the capture that completes the DEBOUNCE_SCANS-th matching scan.
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_SCANS+1).

Decomposition:
- Shared package (keypad_pkg) holds:
  - FSM state encoding: IDLE, CONFIRM, PRESSED, RELEASE
  - keymap constant array KEYMAP[col][row]
  - scan result encoding: NONE, SINGLE, MULTI
- One natural sub-module, keypad_scan_result: combinational classifier that takes the 16 captured bits and returns the result type and the code. The debounce FSM stays in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; a scan is 16 cycles):
- Reset, no key:
  - Stimulus: rst_n low for 3 cycles, then row = 1111 for 10 scans.
  - Required: col rotates every 4 cycles starting at 1110; keyValid never pulses; keyCode = 0.
- Single press:
  - Stimulus: model key "5" (row1 low while col1 is low) for 5 scans.
  - Required: exactly one keyValid pulse, at the end of the 2nd full scan; keyCode = 4'h5; keyHeld = 1.
  - Then release: keyHeld falls after 2 empty scans.
- Bounce:
  - Stimulus: key "D" present for 1 scan, absent for 1 scan, then present for 3 scans.
  - Required: a single keyValid pulse with keyCode = 4'hD, no earlier pulse.
- Multi-key:
  - Stimulus: keys "1" and "A" held together from IDLE.
  - Required: no keyValid.
  - While "3" is in PRESSED, add "E": no new pulse and keyCode stays 4'h3.
- Reset mid-press:
  - Stimulus: assert rst_n while in PRESSED with key "F".
  - Required: all outputs return to reset values immediately. After release of reset with the key still held, keyValid pulses again after 2 scans.
- Back-to-back keys:
  - Stimulus: press "0", release, then press "9".
  - Required: two pulses, with keyCode = 4'h0 then 4'h9.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad encoder: debounce states,
// scan classification and the physical key layout of the 4x4 keypad.
package keypad_pkg;

    // Debounce FSM states, advanced once per completed keypad scan.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } key_state_t;

    // Classification of one full 16-key scan.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_kind_t;

    // Hex code printed on each key, indexed [column][row], rows top to bottom.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

endpackage

// File: rtl/keypad_scan_result.sv
// Classifies the 16 captured row bits of one scan (bit col*4+row, active-low)
// as no key, exactly one key (with its hex code) or several keys.
module keypad_scan_result
    import keypad_pkg::*;
(
    input  logic [15:0] scan_bits,
    output scan_kind_t  kind,
    output logic [3:0]  code
);

    logic [4:0] low_count;

    // Count the pressed keys and remember the code of the last one found.
    always_comb begin
        low_count = '0;
        code      = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!scan_bits[c*4 + r]) begin
                    low_count = low_count + 5'd1;
                    code      = KEYMAP[c][r];
                end
            end
        end
        if (low_count == 5'd0) begin
            kind = NONE;
        end else if (low_count == 5'd1) begin
            kind = SINGLE;
        end else begin
            kind = MULTI;
        end
    end

endmodule

// File: rtl/hex_keypad_encoder.sv
// Scans a 4x4 hex keypad one column at a time, debounces whole-keypad scans
// and reports each accepted press as a hex code with a one-cycle valid pulse
// and a held level that lasts until the release is accepted.
module hex_keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] keyCode,
    output logic       keyValid,
    output logic       keyHeld
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [11:0]   captured;
    logic          capture_now;
    logic          scan_done;
    logic [15:0]   scan_bits;
    scan_kind_t    scan_kind;
    logic [3:0]    scan_code;

    key_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    cand, cand_n;
    logic [3:0]    code_n;
    logic          valid_n;
    logic          held_n;

    assign capture_now = (dwell == DWELL_LAST);
    assign scan_done   = capture_now && (col_idx == 2'd3);
    assign col         = ~(4'b0001 << col_idx);
    // Column 3 is evaluated straight from the synchronizer on its capture cycle.
    assign scan_bits   = {row_sync, captured};
    assign cnt_inc     = cnt + CNT_ONE;

    keypad_scan_result u_scan_result (
        .scan_bits (scan_bits),
        .kind      (scan_kind),
        .code      (scan_code)
    );

    // Two-flop synchronizer for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Column dwell timer, column rotation and per-column row capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell    <= '0;
            col_idx  <= 2'd0;
            captured <= 12'hFFF;
        end else if (capture_now) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            case (col_idx)
                2'd0:    captured[3:0]  <= row_sync;
                2'd1:    captured[7:4]  <= row_sync;
                2'd2:    captured[11:8] <= row_sync;
                default: ;
            endcase
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Debounce state register and registered key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            keyCode  <= '0;
            keyValid <= 1'b0;
            keyHeld  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cand     <= cand_n;
            keyCode  <= code_n;
            keyValid <= valid_n;
            keyHeld  <= held_n;
        end
    end

    // Next-state logic: one decision per completed scan; rollover is ignored while held.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = keyCode;
        valid_n = 1'b0;
        held_n  = keyHeld;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_kind == SINGLE) begin
                        cand_n = scan_code;
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_n = PRESSED;
                            cnt_n   = '0;
                            code_n  = scan_code;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                        end else begin
                            state_n = CONFIRM;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                CONFIRM: begin
                    if (scan_kind == SINGLE) begin
                        if (scan_code == cand) begin
                            cnt_n = cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                state_n = PRESSED;
                                cnt_n   = '0;
                                code_n  = cand;
                                valid_n = 1'b1;
                                held_n  = 1'b1;
                            end
                        end else begin
                            cand_n = scan_code;
                            cnt_n  = CNT_ONE;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (scan_kind == NONE) begin
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                            held_n  = 1'b0;
                        end else begin
                            state_n = RELEASE;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (scan_kind == NONE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                            held_n  = 1'b0;
                        end
                    end else begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_keypad_encoder.sv
// Self-checking bench for hex_keypad_encoder with a fast scan (SCAN_DIV=4,
// DEBOUNCE_SCANS=2): a physical keypad model drives the rows from the column
// drive, and a per-scan press/release model predicts every output cycle.
module tb_hex_keypad_encoder;

    localparam int SCAN_DIV   = 4;
    localparam int DEB        = 2;
    localparam int SCAN_CYCLES = 4 * SCAN_DIV;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] keyCode;
    logic       keyValid;
    logic       keyHeld;

    logic [15:0] pressed;

    int checks;
    int failures;

    // Reference model state: expressed as press/release streaks, not FSM states.
    bit         mHeld;
    int         mPressRun;
    int         mReleaseRun;
    logic [3:0] mCand;
    logic [3:0] mCode;

    hex_keypad_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .keyCode  (keyCode),
        .keyValid (keyValid),
        .keyHeld  (keyHeld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column on which each hex key sits on the keypad face.
    function automatic int keyColOf(input int k);
        case (k)
            1, 4, 7, 0:     return 0;
            2, 5, 8, 15:    return 1;
            3, 6, 9, 14:    return 2;
            default:        return 3;
        endcase
    endfunction

    // Row (top to bottom) on which each hex key sits on the keypad face.
    function automatic int keyRowOf(input int k);
        case (k)
            1, 2, 3, 10:    return 0;
            4, 5, 6, 11:    return 1;
            7, 8, 9, 12:    return 2;
            default:        return 3;
        endcase
    endfunction

    // Physical keypad: a pressed key shorts its row low while its column is driven low.
    always @* begin
        row = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k] && (col[keyColOf(k)] == 1'b0)) begin
                row[keyRowOf(k)] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mHeld       = 1'b0;
        mPressRun   = 0;
        mReleaseRun = 0;
        mCand       = 4'h0;
        mCode       = 4'h0;
    endtask

    // Advance the model by one full scan of the given key set; returns whether a press is accepted.
    task automatic modelScan(input logic [15:0] keys, output bit pulse);
        int         n;
        logic [3:0] c;
        pulse = 1'b0;
        n = $countones(keys);
        c = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (keys[k]) c = 4'(k);
        end
        if (!mHeld) begin
            if (n == 1) begin
                if (mPressRun > 0 && c == mCand) begin
                    mPressRun++;
                end else begin
                    mCand     = c;
                    mPressRun = 1;
                end
                if (mPressRun >= DEB) begin
                    pulse       = 1'b1;
                    mHeld       = 1'b1;
                    mCode       = mCand;
                    mPressRun   = 0;
                    mReleaseRun = 0;
                end
            end else begin
                mPressRun = 0;
            end
        end else begin
            if (n == 0) begin
                mReleaseRun++;
                if (mReleaseRun >= DEB) begin
                    mHeld       = 1'b0;
                    mReleaseRun = 0;
                end
            end else begin
                mReleaseRun = 0;
            end
        end
    endtask

    // Hold a key set for whole scans, checking every output on every cycle; starts and ends at a negedge.
    task automatic applyStimulus(input logic [15:0] keys, input int nScans);
        bit         pulse;
        bit         oldHeld;
        logic [3:0] oldCode;
        logic [3:0] expCol;
        pressed = keys;
        for (int s = 0; s < nScans; s++) begin
            oldHeld = mHeld;
            oldCode = mCode;
            modelScan(keys, pulse);
            for (int i = 1; i <= SCAN_CYCLES; i++) begin
                @(posedge clk);
                @(negedge clk);
                expCol = ~(4'b0001 << ((i / SCAN_DIV) % 4));
                checkOutput("col", {4'h0, col}, {4'h0, expCol});
                checkOutput("keyValid", {7'h0, keyValid}, {7'h0, (i == SCAN_CYCLES) && pulse});
                checkOutput("keyHeld", {7'h0, keyHeld}, {7'h0, (i == SCAN_CYCLES) ? mHeld : oldHeld});
                checkOutput("keyCode", {4'h0, keyCode}, {4'h0, (i == SCAN_CYCLES) ? mCode : oldCode});
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_col"}, {4'h0, col}, 8'h0E);
        checkOutput({tag, "_keyCode"}, {4'h0, keyCode}, 8'h00);
        checkOutput({tag, "_keyValid"}, {7'h0, keyValid}, 8'h00);
        checkOutput({tag, "_keyHeld"}, {7'h0, keyHeld}, 8'h00);
    endtask

    function automatic logic [15:0] keyMask(input int k);
        logic [15:0] m;
        m = 16'h0001 << k;
        return m;
    endfunction

    initial begin
        logic [15:0] mask;
        logic [3:0]  favKey;
        int          pick;

        checks   = 0;
        failures = 0;
        pressed  = 16'h0000;
        rst_n    = 1'b0;
        modelReset();

        // Reset with no key, then ten idle scans.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        applyStimulus(16'h0000, 10);
        checkOutput("idle_keyCode", {4'h0, keyCode}, 8'h00);

        // Single press of "5", then release.
        applyStimulus(keyMask(5), 5);
        checkOutput("press5_keyCode", {4'h0, keyCode}, 8'h05);
        checkOutput("press5_keyHeld", {7'h0, keyHeld}, 8'h01);
        applyStimulus(16'h0000, 3);
        checkOutput("release5_keyHeld", {7'h0, keyHeld}, 8'h00);

        // Bouncing "D".
        applyStimulus(keyMask(13), 1);
        applyStimulus(16'h0000, 1);
        applyStimulus(keyMask(13), 3);
        checkOutput("bounceD_keyCode", {4'h0, keyCode}, 8'h0D);
        applyStimulus(16'h0000, 3);

        // "1" and "A" together from idle, then "3" pressed with "E" rolled over.
        applyStimulus(keyMask(1) | keyMask(10), 4);
        checkOutput("multi_keyHeld", {7'h0, keyHeld}, 8'h00);
        applyStimulus(keyMask(3), 3);
        applyStimulus(keyMask(3) | keyMask(14), 3);
        checkOutput("rollover_keyCode", {4'h0, keyCode}, 8'h03);
        applyStimulus(16'h0000, 3);

        // Reset while "F" is held mid-scan, then recovery with the key still down.
        applyStimulus(keyMask(15), 3);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("midreset");
        modelReset();
        @(negedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(keyMask(15), 3);
        checkOutput("repressF_keyCode", {4'h0, keyCode}, 8'h0F);
        applyStimulus(16'h0000, 3);

        // Back-to-back "0" then "9".
        applyStimulus(keyMask(0), 3);
        applyStimulus(16'h0000, 3);
        applyStimulus(keyMask(9), 3);
        checkOutput("b2b_keyCode", {4'h0, keyCode}, 8'h09);
        applyStimulus(16'h0000, 3);

        // Randomized key traffic: empty scans, a sticky favourite key and occasional rollovers.
        favKey = 4'($urandom_range(0, 15));
        for (int s = 0; s < 60; s++) begin
            pick = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) favKey = 4'($urandom_range(0, 15));
            if (pick < 4) begin
                mask = 16'h0000;
            end else if (pick < 8) begin
                mask = keyMask(int'(favKey));
            end else begin
                mask = keyMask(int'(favKey)) | keyMask(int'($urandom_range(0, 15)));
            end
            applyStimulus(mask, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
